// File: rtl/multi_cycle_alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding and FSM states.
package multi_cycle_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/multi_cycle_alu_if.sv
// Request/result bundle for multi_cycle_alu.
// Optional busy signal is present when MULTI_CYCLE_ALU_BUSY_EN is defined.
interface multi_cycle_alu_if #(
  parameter int WIDTH = 2
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       Op;
  logic [WIDTH:0]   Y;
  logic             done;
`ifdef MULTI_CYCLE_ALU_BUSY_EN
  logic             busy;

  modport master (output start, A, B, Op, input Y, done, busy);
  modport slave  (input start, A, B, Op, output Y, done, busy);
`else
  modport master (output start, A, B, Op, input Y, done);
  modport slave  (input start, A, B, Op, output Y, done);
`endif

endinterface

// File: rtl/multi_cycle_alu_core.sv
// Combinational datapath: captured operands and opcode to a WIDTH+1 bit result.
module multi_cycle_alu_core
  import multi_cycle_alu_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH:0]   result
);

  // Operands are zero-extended so the extra bit carries the carry or borrow
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = {1'b0, a} + {1'b0, b};
      OP_SUB:  result = {1'b0, a} - {1'b0, b};
      OP_AND:  result = {1'b0, a & b};
      OP_OR:   result = {1'b0, a | b};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_alu.sv
// Multi-cycle ALU top: IDLE/EXEC/DONE control, operand capture and result register.
// Define MULTI_CYCLE_ALU_BUSY_EN to drive the busy output.
module multi_cycle_alu
  import multi_cycle_alu_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input logic               clk,
  input logic               reset,
  multi_cycle_alu_if.slave  bus
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  op_t              op_q;
  logic [WIDTH:0]   result;
  logic [WIDTH:0]   y_q;
  logic             done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operands are only sampled when a request is accepted, so later input changes are invisible
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
    end else if (state == IDLE && bus.start) begin
      a_q  <= bus.A;
      b_q  <= bus.B;
      op_q <= op_t'(bus.Op);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= '0;
    end else if (state == EXEC) begin
      y_q <= result;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  multi_cycle_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (result)
  );

  assign bus.Y    = y_q;
  assign bus.done = done;

`ifdef MULTI_CYCLE_ALU_BUSY_EN
  // Reset forces busy low immediately, even before the state register clears
  assign bus.busy = !reset && (state != IDLE);
`endif

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Self-checking bench for multi_cycle_alu: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_multi_cycle_alu;
  import multi_cycle_alu_pkg::*;

  localparam int WIDTH = 2;
  localparam int RMASK = (1 << (WIDTH + 1)) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multi_cycle_alu_if #(.WIDTH(WIDTH)) bus ();

  multi_cycle_alu #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic reduced modulo 2^(WIDTH+1)
  function automatic int model(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      default: r = a | b;
    endcase
    return r & RMASK;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkBusy(input string tag, input int expected);
`ifdef MULTI_CYCLE_ALU_BUSY_EN
    checkOutput(tag, int'(bus.busy), expected);
`else
    if (tag.len() < 0) $display("[TB] %s %0d", tag, expected);
`endif
  endtask

  task automatic applyStimulus(input int a, input int b, input int op);
    @(negedge clk);
    bus.A     = WIDTH'(a);
    bus.B     = WIDTH'(b);
    bus.Op    = 2'(op);
    bus.start = 1'b1;
  endtask

  // One full operation with a single-cycle start pulse; checks every cycle of the transaction
  task automatic runOp(input string tag, input int a, input int b, input int op);
    int exp;
    exp = model(a, b, op);
    applyStimulus(a, b, op);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput({tag, "_exec_done"}, int'(bus.done), 0);
    checkBusy({tag, "_exec_busy"}, 1);
    @(negedge clk);
    checkOutput({tag, "_done"}, int'(bus.done), 1);
    checkOutput({tag, "_y"}, int'(bus.Y), exp);
    checkBusy({tag, "_done_busy"}, 1);
    @(negedge clk);
    checkOutput({tag, "_done_drop"}, int'(bus.done), 0);
    checkOutput({tag, "_y_hold"}, int'(bus.Y), exp);
    checkBusy({tag, "_idle_busy"}, 0);
  endtask

  initial begin
    int a;
    int b;
    int op;
    int pulses;

    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Op    = '0;

    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_y", int'(bus.Y), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkBusy("reset_busy", 0);
    @(negedge clk);
    checkOutput("idle_done", int'(bus.done), 0);

    runOp("add_1_2", 1, 2, 0);
    runOp("sub_3_1", 3, 1, 1);
    runOp("sub_0_1", 0, 1, 1);
    runOp("and_3_2", 3, 2, 2);
    runOp("or_2_1", 2, 1, 3);
    runOp("add_3_3", 3, 3, 0);

    // Y must hold across idle cycles
    repeat (3) @(negedge clk);
    checkOutput("hold_y", int'(bus.Y), model(3, 3, 0));

    // Inputs and start changed during EXEC must not affect the captured operation
    applyStimulus(2, 3, 1);
    @(negedge clk);
    bus.A  = 2'd3;
    bus.B  = 2'd3;
    bus.Op = 2'd3;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("capture_done", int'(bus.done), 1);
    checkOutput("capture_y", int'(bus.Y), model(2, 3, 1));
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    checkOutput("capture_no_second_done", pulses, 0);
    checkOutput("capture_y_kept", int'(bus.Y), model(2, 3, 1));

    // Reset during EXEC aborts the operation
    applyStimulus(3, 3, 0);
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_y", int'(bus.Y), 0);
    checkOutput("abort_done", int'(bus.done), 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    checkOutput("abort_no_done", pulses, 0);
    checkOutput("abort_y_stays", int'(bus.Y), 0);
    runOp("after_abort", 1, 1, 0);

    // Reset wins over start on the same edge
    @(negedge clk);
    bus.A     = 2'd2;
    bus.B     = 2'd2;
    bus.Op    = 2'd0;
    bus.start = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("reset_prio_done", int'(bus.done), 0);
    @(negedge clk);
    checkOutput("reset_prio_y", int'(bus.Y), 0);

    // start held high: a new operation every third cycle
    applyStimulus(1, 3, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_done_%0d", i), int'(bus.done), (i % 3 == 1) ? 1 : 0);
    end
    bus.start = 1'b0;
    checkOutput("b2b_y", int'(bus.Y), model(1, 3, 0));
    repeat (3) @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      a  = int'($urandom_range(0, (1 << WIDTH) - 1));
      b  = int'($urandom_range(0, (1 << WIDTH) - 1));
      op = int'($urandom_range(0, 3));
      runOp($sformatf("rand%0d_a%0d_b%0d_op%0d", n, a, b, op), a, b, op);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
